// File: rtl/alu_op_sequencer_if.sv
// Bundle of the command, ALU-stage and result signals of alu_op_sequencer.
//   slave  : the sequencer side (accepts commands, drives ALU operands,
//            captures ALU results, presents them to the consumer)
//   master : the environment side (command producer, ALU stage, consumer)
// DEPTH must match the sequencer's DEPTH so that count has the same width.
interface alu_op_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic [3:0]    in_op;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_s;
  logic [15:0]   alu_y;
  logic          alu_carry;
  logic          alu_zero;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_y;
  logic          out_carry;
  logic          out_zero;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_y, alu_carry, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_s, out_valid, out_y, out_carry, out_zero,
    count
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_y, alu_carry, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_s, out_valid, out_y, out_carry, out_zero,
    count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands in a DEPTH-entry FIFO and issues
// them one at a time to an external ALU stage of latency ALU_LAT. Each
// result is captured and held for the consumer until out_ready.
// Ports:
//   clk : clock, all state changes on the rising edge
//   en  : synchronous active-high reset
//   bus : alu_op_sequencer_if.slave (command in, ALU operands out,
//         ALU result in, captured result out, FIFO occupancy)
module alu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input logic             clk,
  input logic             en,
  alu_op_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t        state;
  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] wait_cnt;
  logic          rst_busy;
  logic          push;
  logic          pop;
  logic [19:0]   head;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_s;
  logic          out_valid;
  logic [15:0]   out_y;
  logic          out_carry;
  logic          out_zero;

  // rst_busy keeps in_ready low for the cycle following a reset edge, so
  // in_ready depends on registers only (never on out_ready or a pop).
  assign bus.in_ready = !rst_busy && (count != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign head         = mem[rd_ptr];

  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_s     = alu_s;
  assign bus.out_valid = out_valid;
  assign bus.out_y     = out_y;
  assign bus.out_carry = out_carry;
  assign bus.out_zero  = out_zero;
  assign bus.count     = count;

  always_ff @(posedge clk) begin
    if (push && !en) begin
      mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_op};
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      rst_busy  <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      rst_busy <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      case (state)
        IDLE: begin
          // The head was written on an earlier edge, so a command pushed on
          // this edge can never be issued on it.
          if (count != '0) begin
            {alu_a, alu_b, alu_s} <= head;
            wait_cnt <= LW'(ALU_LAT);
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Counter reaches zero ALU_LAT edges after issue; capture happens
          // on the following edge, once the ALU output has settled.
          if (wait_cnt == '0) begin
            out_y     <= bus.alu_y;
            out_carry <= bus.alu_carry;
            out_zero  <= bus.alu_zero;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - LW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized, scoreboard-checked bench for alu_op_sequencer. The bench
// supplies an ALU stage of latency ALU_LAT and predicts every result from
// the command alone; a negedge monitor pops predictions on each handshake.
module tb_alu_op_sequencer;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;

  logic clk = 1'b0;
  logic en;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DEPTH(DEPTH)) bus();

  alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk (clk),
    .en  (en),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [17:0] exp_q[$];
  logic [17:0] pipe [ALU_LAT];

  // Reference ALU: returns {carry, zero, y}.
  function automatic logic [17:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s);
    logic [16:0] r;
    case (s)
      4'd0:    r = 17'(a) + 17'(b);
      4'd1:    r = 17'(a) - 17'(b);
      4'd2:    r = 17'(a) * 17'(b);
      4'd6:    r = 17'(a & b);
      4'd7:    r = 17'(a | b);
      4'd8:    r = 17'(a ^ b);
      default: r = {1'b0, a, b};
    endcase
    return {r[16], (r[15:0] == 16'h0000), r[15:0]};
  endfunction

  // ALU stage: result valid ALU_LAT rising edges after the operands change.
  always @(posedge clk) begin
    pipe[0] <= alu_f(bus.alu_a, bus.alu_b, bus.alu_s);
    for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {bus.alu_carry, bus.alu_zero, bus.alu_y} = pipe[ALU_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor.
  logic [15:0] prev_y;
  logic        prev_hold = 1'b0;
  always @(negedge clk) begin
    logic [17:0] e;
    if (!en && bus.in_valid && bus.in_ready)
      exp_q.push_back(alu_f(bus.in_a, bus.in_b, bus.in_op));
    if (!en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got y=%h with no command pending, expected none", bus.out_y);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({bus.out_carry, bus.out_zero, bus.out_y}), 32'(e));
      end
    end
    if (prev_hold && !en)
      check("hold_stable", 32'({bus.out_valid, bus.out_y}), 32'({1'b1, prev_y}));
    prev_hold = !en && bus.out_valid && !bus.out_ready;
    prev_y    = bus.out_y;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
    bus.out_ready = 1'b0;
  endtask

  // One command into an empty, idle sequencer; measures push-to-valid edges.
  task automatic run_single(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int lat;
    logic [17:0] e;
    e = alu_f(a, b, op);
    bus.in_a = a; bus.in_b = b; bus.in_op = op;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();                       // push edge P
    bus.in_valid = 1'b0;
    tick();                       // issue edge P+1
    check("issue_alu_s", 32'(bus.alu_s), 32'(op));
    lat = 1;
    while (lat < 12 && !bus.out_valid) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(1 + ALU_LAT + 1));
    check("single_y", 32'(bus.out_y), 32'(e[15:0]));
    check("single_zero", 32'(bus.out_zero), 32'(e[16]));
    tick();
    check("one_cycle_pulse", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] sa, sb;
    logic [3:0] ss;
    logic [15:0] sy;
    logic [2:0] sc;
    logic seen_valid;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
    bus.out_ready = 1'b0;
    en = 1'b1;

    repeat (3) tick();
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_outputs", 32'({bus.out_valid, bus.out_carry, bus.out_zero, bus.out_y}), 32'd0);
    check("reset_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_s}), 32'd0);
    en = 1'b0;
    tick();
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    run_single(8'hF0, 8'h3C, 4'd6);
    check("and_result", 32'(bus.out_y), 32'h0030);
    run_single(8'h55, 8'h55, 4'd8);
    check("zero_flag", 32'({bus.out_zero, bus.out_y}), 32'h10000);
    tick();

    // Fill with the consumer stalled.
    for (int k = 0; k < 5; k++) begin
      bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = 4'($urandom);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
    repeat (2) tick();
    bus.in_valid = 1'b0;
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);

    // Backpressure in HOLD.
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    check("hold_reached", 32'(bus.out_valid), 32'd1);
    sa = bus.alu_a; sb = bus.alu_b; ss = bus.alu_s; sy = bus.out_y; sc = bus.count;
    repeat (10) tick();
    check("bp_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_s}), 32'({sa, sb, ss}));
    check("bp_out", 32'({bus.out_valid, bus.out_y}), 32'({1'b1, sy}));
    check("bp_count", 32'(bus.count), 32'(sc));
    drain();

    // Push and pop on the same edge with two entries queued.
    for (int k = 0; k < 3; k++) begin
      bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = 4'($urandom);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    check("pp_count_before", 32'(bus.count), 32'd2);
    bus.out_ready = 1'b1;
    tick();                       // handshake edge
    bus.out_ready = 1'b0;
    bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = 4'($urandom);
    bus.in_valid = 1'b1;
    tick();                       // issue and push together
    bus.in_valid = 1'b0;
    check("pp_count_after", 32'(bus.count), 32'd2);
    drain();

    // Reset one edge after issue.
    bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_op = 4'd0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();                       // push
    bus.in_valid = 1'b0;
    tick();                       // issue E0
    en = 1'b1;
    tick();                       // reset at E0+1
    en = 1'b0;
    exp_q.delete();
    check("midwait_count", 32'(bus.count), 32'd0);
    check("midwait_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_s}), 32'd0);
    check("midwait_in_ready", 32'(bus.in_ready), 32'd0);
    seen_valid = bus.out_valid;
    repeat (6) begin
      tick();
      seen_valid = seen_valid | bus.out_valid;
    end
    check("midwait_no_pulse", 32'(seen_valid), 32'd0);
    run_single(8'($urandom), 8'($urandom), 4'($urandom));
    tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(9) < 6);
      bus.in_a      = 8'($urandom);
      bus.in_b      = ($urandom_range(7) == 0) ? bus.in_a : 8'($urandom);
      bus.in_op     = 4'($urandom);
      bus.out_ready = 1'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 Parameter ALU_LAT, default 2, rising edges from ALU operand change to valid alu_y/alu_carry/alu_zero.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 en  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  command offered.
REQ-006 in_ready  output  1  command FIFO can accept.
REQ-007 in_a, in_b  input  8 each  operands.
REQ-008 in_op  input  4  ALU select code, passed unmodified.
REQ-009 alu_a, alu_b  output  8 each  registered operands to the ALU stage.
REQ-010 alu_s  output  4  registered select to the ALU stage.
REQ-011 alu_y  input  16  ALU result.
REQ-012 alu_carry, alu_zero  input  1 each  ALU flags.
REQ-013 out_valid  output  1  result held for consumer.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_y  output  16  captured result.
REQ-016 out_carry, out_zero  output  1 each  captured flags.
REQ-017 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-018 in_ready SHALL equal (count != DEPTH), from registered count only; no combinational path from out_ready or pop.
REQ-019 Push SHALL occur on an edge with in_valid && in_ready, writing {in_a,in_b,in_op} at the tail.
REQ-020 FIFO SHALL be strictly ordered; no bypass: a command pushed at edge P is not issued before edge P+1.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 When full, in_ready SHALL be 0 even on a pop edge; push then happens no earlier than next edge.
REQ-023 FSM states: IDLE, WAIT, HOLD.
REQ-024 IDLE with count>0: on the edge pop head into alu_a/alu_b/alu_s, load wait counter with ALU_LAT, go WAIT (the issue edge, E0).
REQ-025 IDLE with count==0: alu_* SHALL hold previous values.
REQ-026 WAIT: counter decrements each edge; on edge E(ALU_LAT+1) capture alu_y/alu_carry/alu_zero into out_y/out_carry/out_zero, set out_valid=1, go HOLD.
REQ-027 alu_a/alu_b/alu_s SHALL stay stable from E0 through capture.
REQ-028 HOLD: out_valid and out_* SHALL hold until an edge with out_ready=1; on that edge out_valid<=0, go IDLE.
REQ-029 Next issue SHALL occur no earlier than the edge after the handshake edge; one command in flight at most.
REQ-030 out_y/flags SHALL pass through ALU values bit-exact; no arithmetic in this block.
REQ-031 Minimum latency, accept into empty FIFO at edge P to out_valid high: 1 + ALU_LAT + 1 = 4 edges at default (out_valid high after P+4).
REQ-032 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-033 en=1 at an edge SHALL set: FIFO empty, count=0, state IDLE, counter 0, alu_a=alu_b=0, alu_s=0, out_valid=0, out_y=0, out_carry=out_zero=0.
REQ-034 en=1 mid-WAIT or mid-HOLD SHALL discard the in-flight command and result; no out_valid pulse follows.
REQ-035 While en=1, in_ready SHALL be 0 and pushes ignored; in_ready=1 from the first edge after en deasserts.
REQ-036 en SHALL take priority over push, pop, capture and handshake on the same edge.

Verification
REQ-037 Single op: after reset push a=8'hF0,b=8'h3C,op=6 at edge P, out_ready=1 -> alu_s=6 after P+1, out_valid high after P+4, out_y=16'h0030, out_zero=0, one-cycle pulse.
REQ-038 Fill: push 5 commands back-to-back with out_ready=0 -> count reaches 4 (one issued), in_ready=0, 5th+ held; results emerge in push order once out_ready=1.
REQ-039 Backpressure: hold out_ready=0 10 cycles in HOLD -> out_y stable, no new issue (alu_* unchanged), count unchanged.
REQ-040 Zero flag: op=8, a=b=8'h55 -> out_y=16'h0000, out_zero copies alu_zero from the attached ALU stage.
REQ-041 Reset mid-WAIT: en=1 one cycle at E0+1 -> out_valid stays 0, count=0, alu_a=alu_b=0, alu_s=0; next push processed normally with latency per REQ-031.
REQ-042 Push+pop at count=2 same edge -> count stays 2, FIFO order preserved (checked by scoreboard).
